// File: rtl/calc_seq_ctrl.sv
// Keypad sequencer for the mini-calculator ALU: collects A, B and opcode one nibble
// per key strobe, holds the ALU inputs for EXEC_CYC cycles, then captures result and flags.
module calc_seq_ctrl #(
  parameter int W        = 12,
  parameter int EXEC_CYC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   din,
  input  logic         key_vld,
  input  logic         key_clr,
  input  logic         key_chn,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_s,
  input  logic [W-1:0] alu_o,
  input  logic         alu_err,
  input  logic         alu_l,
  input  logic         alu_uof,
  output logic [W-1:0] disp_val,
  output logic [3:0]   disp_stat,
  output logic         busy,
  output logic         done
);

  localparam int NIB = W / 4;
  localparam int CW  = $clog2(NIB + 1);
  localparam int EW  = (EXEC_CYC > 1) ? $clog2(EXEC_CYC) : 1;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q, b_q, res_q;
  logic [3:0]      s_q;
  logic            err_q, l_q, uof_q;
  logic [CW-1:0]   cnt;
  logic [EW-1:0]   exec_cnt;
  logic            busy_q;

  // Operand entry is decimal-style: each new nibble pushes the older ones up.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [3:0] n);
    return (v << 4) | W'(n);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      l_q      <= 1'b0;
      uof_q    <= 1'b0;
      cnt      <= '0;
      exec_cnt <= '0;
      busy_q   <= 1'b0;
    end else if (key_clr) begin
      state    <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      l_q      <= 1'b0;
      uof_q    <= 1'b0;
      cnt      <= '0;
      exec_cnt <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state)
        S_A: if (key_vld) begin
          a_q <= shift_in(a_q, din);
          if (cnt == CW'(NIB - 1)) begin
            cnt   <= '0;
            state <= S_B;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_B: if (key_vld) begin
          b_q <= shift_in(b_q, din);
          if (cnt == CW'(NIB - 1)) begin
            cnt   <= '0;
            state <= S_OP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_OP: if (key_vld) begin
          s_q      <= din;
          exec_cnt <= EW'(EXEC_CYC - 1);
          busy_q   <= 1'b1;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_cnt == '0) begin
            res_q  <= alu_o;
            err_q  <= alu_err;
            l_q    <= alu_l;
            uof_q  <= alu_uof;
            busy_q <= 1'b0;
            state  <= S_SHOW;
          end else begin
            exec_cnt <= exec_cnt - 1'b1;
          end
        end
        S_SHOW: begin
          if (key_chn) begin
            a_q   <= res_q;
            b_q   <= '0;
            cnt   <= '0;
            state <= S_B;
          end else if (key_vld) begin
            // The key that leaves the result view is already the first digit of A.
            a_q <= W'(din);
            b_q <= '0;
            if (NIB == 1) begin
              cnt   <= '0;
              state <= S_B;
            end else begin
              cnt   <= CW'(1);
              state <= S_A;
            end
          end
        end
        default: begin
          state  <= S_A;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_s = s_q;
  assign busy  = busy_q;
  // A clear arriving in the capture cycle wins, so no pulse is shown for an aborted run.
  assign done  = busy_q && (exec_cnt == '0) && !key_clr;

  always_comb begin
    disp_val  = a_q;
    disp_stat = 4'h0;
    unique case (state)
      S_A:            disp_val = a_q;
      S_B:            disp_val = b_q;
      S_OP:           disp_val = W'(s_q);
      S_EXEC, S_SHOW: disp_val = res_q;
      default:        disp_val = a_q;
    endcase
    if (state == S_SHOW) begin
      if (err_q)      disp_stat = 4'hA;
      else if (l_q)   disp_stat = 4'h2;
      else if (uof_q) disp_stat = 4'h8;
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Randomized bench for calc_seq_ctrl: one instance with EXEC_CYC=1 and one with EXEC_CYC=4,
// each driven through operand entry, execution, chaining, clear-abort and async reset.
module tb_calc_seq_ctrl;

  localparam int W   = 12;
  localparam int NIB = W / 4;
  localparam int N_IT = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   din [2];
  logic         key_vld [2];
  logic         key_clr [2];
  logic         key_chn [2];
  logic [W-1:0] alu_o;
  logic         alu_err, alu_l, alu_uof;
  logic [W-1:0] alu_a [2];
  logic [W-1:0] alu_b [2];
  logic [W-1:0] disp_val [2];
  logic [3:0]   alu_s [2];
  logic [3:0]   disp_stat [2];
  logic         busy [2];
  logic         done [2];

  calc_seq_ctrl #(.W(W), .EXEC_CYC(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .key_vld(key_vld[0]), .key_clr(key_clr[0]),
    .key_chn(key_chn[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_s(alu_s[0]),
    .alu_o(alu_o), .alu_err(alu_err), .alu_l(alu_l), .alu_uof(alu_uof),
    .disp_val(disp_val[0]), .disp_stat(disp_stat[0]), .busy(busy[0]), .done(done[0])
  );

  calc_seq_ctrl #(.W(W), .EXEC_CYC(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .din(din[1]), .key_vld(key_vld[1]), .key_clr(key_clr[1]),
    .key_chn(key_chn[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_s(alu_s[1]),
    .alu_o(alu_o), .alu_err(alu_err), .alu_l(alu_l), .alu_uof(alu_uof),
    .disp_val(disp_val[1]), .disp_stat(disp_stat[1]), .busy(busy[1]), .done(done[1])
  );

  typedef struct {
    bit         chain;
    logic [W-1:0] a, b;
    logic [3:0]   s;
    logic [W-1:0] o;
    bit         e, l, f;
  } vec_t;

  vec_t dir [5];
  int   vectors = 0;
  int   miscompares = 0;
  int   cur_u = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL u%0d %s: got %0h expected %0h", cur_u, tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] stat_code(input bit e, input bit l, input bit f);
    if (e) return 4'hA;
    if (l) return 4'h2;
    if (f) return 4'h8;
    return 4'h0;
  endfunction

  task automatic chk_zero(input int u, input string tag);
    chk({tag, "_a"}, alu_a[u], 0);
    chk({tag, "_b"}, alu_b[u], 0);
    chk({tag, "_s"}, alu_s[u], 0);
    chk({tag, "_disp"}, disp_val[u], 0);
    chk({tag, "_stat"}, disp_stat[u], 0);
    chk({tag, "_busy"}, busy[u], 0);
    chk({tag, "_done"}, done[u], 0);
  endtask

  task automatic press(input int u, input logic [3:0] n, input bit vld, input bit chn);
    @(negedge clk);
    din[u] = n;
    key_vld[u] = vld;
    key_chn[u] = chn;
    @(negedge clk);
    key_vld[u] = 1'b0;
    key_chn[u] = 1'b0;
  endtask

  task automatic do_reset(input int u);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero(u, "rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero(u, "rst_rel");
  endtask

  task automatic run_unit(input int u);
    int           e_cyc;
    logic [W-1:0] res, a, b, o;
    logic [3:0]   s, sprev;
    bit           valid_res, chain, fe, fl, ff, abort, rst_mid, chn_vld, skip;
    int           abort_at;
    cur_u = u;
    e_cyc = (u == 0) ? 1 : 4;
    res = '0;
    sprev = '0;
    valid_res = 0;
    do_reset(u);
    for (int it = 0; it < N_IT; it++) begin
      skip = 0;
      if (it < 5) begin
        chain = dir[it].chain; a = dir[it].a; b = dir[it].b; s = dir[it].s;
        o = dir[it].o; fe = dir[it].e; fl = dir[it].l; ff = dir[it].f;
        abort = 0; rst_mid = 0; chn_vld = 0;
      end else begin
        chain = (it == 5) || ($urandom_range(0, 1) == 1);
        a = W'($urandom); b = W'($urandom); s = 4'($urandom); o = W'($urandom);
        fe = ($urandom_range(0, 3) == 0); fl = ($urandom_range(0, 2) == 0);
        ff = ($urandom_range(0, 2) == 0);
        abort   = (it == 6) || (it > 8 && $urandom_range(0, 7) == 0);
        rst_mid = (it == 7) || (it > 8 && $urandom_range(0, 9) == 0);
        chn_vld = (it == 5) || ($urandom_range(0, 1) == 1);
      end
      if (!valid_res) chain = 0;

      if (chain) begin
        a = res;
        press(u, 4'($urandom), chn_vld, 1'b1);
        chk("chain_a", alu_a[u], a);
        chk("chain_b", alu_b[u], 0);
        chk("chain_disp", disp_val[u], 0);
        chk("chain_stat", disp_stat[u], 0);
      end else begin
        for (int i = NIB - 1; i >= 0; i--) begin
          press(u, a[4*i +: 4], 1'b1, 1'b0);
          if (i > 0) begin
            chk("a_entry", disp_val[u], a >> (4 * i));
            chk("a_entry_b", alu_b[u], 0);
            chk("a_entry_stat", disp_stat[u], 0);
          end
        end
        chk("a_done", alu_a[u], a);
        chk("a_done_disp", disp_val[u], 0);
      end

      for (int i = NIB - 1; i >= 0; i--) begin
        press(u, b[4*i +: 4], 1'b1, 1'b0);
        if (rst_mid && (NIB - 1 - i) == 2) begin
          do_reset(u);
          skip = 1;
          break;
        end
        if (i > 0) chk("b_entry", disp_val[u], b >> (4 * i));
      end
      if (skip) begin
        res = '0; sprev = '0; valid_res = 0;
        continue;
      end
      chk("b_done", alu_b[u], b);
      chk("op_disp", disp_val[u], W'(sprev));

      alu_o = o; alu_err = fe; alu_l = fl; alu_uof = ff;
      press(u, s, 1'b1, 1'b0);
      sprev = s;
      abort_at = abort ? $urandom_range(1, e_cyc) : 0;
      for (int k = 1; k <= e_cyc; k++) begin
        chk("exec_busy", busy[u], 1);
        chk("exec_a", alu_a[u], a);
        chk("exec_b", alu_b[u], b);
        chk("exec_s", alu_s[u], s);
        chk("exec_disp", disp_val[u], res);
        if (k == abort_at) begin
          key_clr[u] = 1'b1;
          key_vld[u] = 1'b1;
          din[u] = 4'($urandom);
          #1 chk("abort_done", done[u], 0);
          @(negedge clk);
          key_clr[u] = 1'b0;
          key_vld[u] = 1'b0;
          chk_zero(u, "abort");
          skip = 1;
          break;
        end
        chk("exec_done", done[u], (k == e_cyc) ? 1 : 0);
        key_vld[u] = ($urandom_range(0, 1) == 1);
        key_chn[u] = ($urandom_range(0, 2) == 0);
        din[u] = 4'($urandom);
        @(negedge clk);
        key_vld[u] = 1'b0;
        key_chn[u] = 1'b0;
      end
      if (skip) begin
        res = '0; sprev = '0; valid_res = 0;
        continue;
      end

      res = o;
      valid_res = 1;
      chk("show_busy", busy[u], 0);
      chk("show_done", done[u], 0);
      chk("show_disp", disp_val[u], o);
      chk("show_stat", disp_stat[u], stat_code(fe, fl, ff));
      chk("show_a", alu_a[u], a);
      alu_o = W'($urandom); alu_err = 0; alu_l = 0; alu_uof = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("show_hold", disp_val[u], o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      din[u] = '0; key_vld[u] = 0; key_clr[u] = 0; key_chn[u] = 0;
    end
    alu_o = '0; alu_err = 0; alu_l = 0; alu_uof = 0;
    dir[0] = '{chain: 0, a: 12'h1F4, b: 12'h0C8, s: 4'h0, o: 12'h2BC, e: 0, l: 0, f: 0};
    dir[1] = '{chain: 1, a: 12'h000, b: 12'h064, s: 4'h1, o: 12'h258, e: 0, l: 0, f: 0};
    dir[2] = '{chain: 0, a: 12'h123, b: 12'h456, s: 4'h7, o: 12'h001, e: 1, l: 1, f: 0};
    dir[3] = '{chain: 0, a: 12'h300, b: 12'h200, s: 4'h4, o: 12'h000, e: 0, l: 1, f: 0};
    dir[4] = '{chain: 0, a: 12'hFFF, b: 12'h001, s: 4'h0, o: 12'h000, e: 0, l: 0, f: 1};
    #3;
    rst_n = 1'b1;
    run_unit(0);
    run_unit(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
